conv3x3_mac_stage: RTL and testbench
====================================

Name: conv3x3_mac_stage

Overview:
- Downstream consumer of the 3x3 stride-2 window generator.
- Takes the nine window pixels and their valid strobe, and computes a signed 3x3 dot product with a runtime-loaded coefficient set plus bias.
- Applies rounding, right shift, ReLU and saturation, and emits one unsigned pixel per window.
- Tracks output raster position and flags the last pixel of each output frame.

Parameters:
- DATA_WIDHT, 8: width of the unsigned pixel in and out.
- COEF_WIDTH, 8: width of the signed coefficients and the bias.
- SHIFT, 6: fixed-point fraction bits of the coefficients (64 = 1.0). Legal range 1..COEF_WIDTH-1.
- IMG_WIDHT, 299: input image width. Output width is OUT_W = (IMG_WIDHT-3)/2+1 = 149 (localparam).
- IMG_HEIGHT, 299: input image height. Output height is OUT_H = (IMG_HEIGHT-3)/2+1 = 149 (localparam).
- ACC_WIDTH: localparam, DATA_WIDHT+COEF_WIDTH+5, signed accumulator width.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: reset, asynchronous, active-high.
- Data_In1..Data_In9, in, DATA_WIDHT each: unsigned window pixels, row-major (1 = top-left, 5 = centre, 9 = bottom-right).
- Valid_In, in, 1: window valid, one window per asserted cycle.
- Coef_In, in, COEF_WIDTH: signed coefficient or bias word.
- Coef_Valid, in, 1: Coef_In write strobe.
- Coef_Ready, out, 1: high when all 10 words are loaded.
- Data_Out, out, DATA_WIDHT: result pixel.
- Valid_Out, out, 1: Data_Out valid.
- Frame_Done, out, 1: one-cycle pulse coincident with the last Valid_Out of a frame.

Behaviour:
- Reset (async, rst=1):
  - All coefficients, bias, load counter, pipeline registers and raster counters go to 0.
  - Coef_Ready=0, Data_Out=0, Valid_Out=0, Frame_Done=0.
  - Reset mid-frame discards in-flight data. The frame restarts at raster (0,0) after the coefficient reload.
- Coefficient load:
  - 4-bit index counter. Each Coef_Valid cycle writes Coef_In to K[idx]: idx 0..8 = K1..K9, idx 9 = bias B.
  - After idx 9 is written: Coef_Ready=1 on the next cycle and idx returns to 0.
  - Coef_Valid while Coef_Ready=1 clears Coef_Ready in the same edge and starts a new load at idx 0 (writes K1).
- Acceptance: Valid_In is honoured only when Coef_Ready=1. Otherwise the window is dropped and no output is produced.
- Pipeline, fixed latency 3 cycles (Valid_In at edge N gives Valid_Out at edge N+3), no backpressure, full throughput:
  - S1: P_i = zero-extended Data_In_i times signed K_i (signed, DATA_WIDHT+COEF_WIDTH+1 bits). Registers all nine products, plus B sign-extended and shifted left by SHIFT.
  - S2: three row partial sums, each a sum of 3 products; bias carried along.
  - S3: ACC = sum of the rows + bias + 2^(SHIFT-1), which gives round-half-up. Then:
    - If ACC < 0: Data_Out = 0.
    - Otherwise R = ACC >>> SHIFT, and Data_Out = min(R, 2^DATA_WIDHT-1).
- Coefficient consistency: products and bias are captured in S1. A coefficient reload therefore never affects windows already in S2/S3.
- Valid bits shift with the data. Data_Out holds its last value when Valid_Out=0.
- Raster counters col (0..OUT_W-1) and row (0..OUT_H-1) advance on each Valid_Out.
  - Frame_Done=1 in the cycle where Valid_Out=1 and col=OUT_W-1 and row=OUT_H-1.
  - Both counters then wrap to 0. Back-to-back frames need no gap.
- ACC_WIDTH is sized so that no overflow is possible for any input or coefficient combination.

Decomposition:
- Shared package (conv_pkg):
  - Default DATA_WIDHT/COEF_WIDTH/SHIFT.
  - An OUT_DIM(img) function giving (img-3)/2+1.
  - The ACC_WIDTH formula.
  - The coefficient index constants (BIAS_IDX=9).
- One natural sub-module: relu_round_sat, the S3 round/ReLU/shift/saturate datapath, parameterised by ACC_WIDTH, SHIFT and DATA_WIDHT. It is reused later by the pooling and 1x1 stages.

Test Plan:
- Identity: load K5=64, others 0, B=0. Window with centre 100 -> Data_Out=100 exactly 3 cycles after Valid_In. Then 200 back-to-back -> 200 on the next cycle.
- Saturation/ReLU: all K=64, all pixels 255 -> 255. K5=-64 with centre 50 -> 0.
- Rounding/bias:
  - K5=32, centre 3 -> 2 (1.5 rounds up). Centre 1 -> 1 (0.5 rounds up).
  - All K=0, B=10 -> 10 for any window. B=-1 -> 0.
- Load gating: Valid_In pulses before the 10th Coef_Valid -> no Valid_Out. A reload issued while 3 windows are in flight -> those outputs use the old set, and Coef_Ready drops in the cycle of the first new word.
- Frame: 22201 (149x149) consecutive valid windows -> exactly one Frame_Done, on output 22201. The next frame's first output has col=row=0.
- Async reset: assert rst mid-frame between clock edges -> outputs clear immediately and Coef_Ready=0. After reload, the next Frame_Done occurs after 22201 more outputs.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and sizing helpers for the convolution pipeline stages.
package conv_pkg;

  localparam int unsigned DEF_DATA_WIDHT = 8;
  localparam int unsigned DEF_COEF_WIDTH = 8;
  localparam int unsigned DEF_SHIFT      = 6;

  // Coefficient bank layout: K1..K9 at 0..8, bias last.
  localparam int unsigned NUM_TAPS = 9;
  localparam int unsigned BIAS_IDX = 9;
  localparam int unsigned NUM_COEF = 10;

  // Output dimension of a 3x3 stride-2 valid window over an image of size img.
  function automatic int unsigned OUT_DIM(input int unsigned img);
    return (img - 3) / 2 + 1;
  endfunction

  // Signed accumulator width that cannot overflow for any pixel/coefficient mix.
  function automatic int unsigned ACC_W(input int unsigned dw, input int unsigned cw);
    return dw + cw + 5;
  endfunction

endpackage

// File: rtl/relu_round_sat.sv
// Round-half-up, ReLU, fixed-point right shift and unsigned saturation.
module relu_round_sat #(
  parameter int unsigned ACC_WIDTH  = 21,
  parameter int unsigned SHIFT      = 6,
  parameter int unsigned DATA_WIDHT = 8
) (
  input  logic signed [ACC_WIDTH-1:0]  acc_i,
  output logic        [DATA_WIDHT-1:0] pix_o
);

  localparam logic signed [ACC_WIDTH-1:0] RoundConst = ACC_WIDTH'(1 << (SHIFT - 1));
  localparam logic signed [ACC_WIDTH-1:0] MaxPix     = ACC_WIDTH'((1 << DATA_WIDHT) - 1);

  logic signed [ACC_WIDTH-1:0] rounded;
  logic signed [ACC_WIDTH-1:0] shifted;

  // Negative results clamp to zero; large positive results clamp to full scale.
  always_comb begin
    rounded = acc_i + RoundConst;
    shifted = rounded >>> SHIFT;
    if (rounded[ACC_WIDTH-1]) begin
      pix_o = '0;
    end else if (shifted > MaxPix) begin
      pix_o = '1;
    end else begin
      pix_o = shifted[DATA_WIDHT-1:0];
    end
  end

endmodule

// File: rtl/conv3x3_mac_stage.sv
// 3x3 signed MAC with runtime coefficients, 3-stage pipeline, raster tracking.
module conv3x3_mac_stage
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDHT = DEF_DATA_WIDHT,
  parameter int unsigned COEF_WIDTH = DEF_COEF_WIDTH,
  parameter int unsigned SHIFT      = DEF_SHIFT,
  parameter int unsigned IMG_WIDHT  = 299,
  parameter int unsigned IMG_HEIGHT = 299
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDHT-1:0] Data_In1,
  input  logic [DATA_WIDHT-1:0] Data_In2,
  input  logic [DATA_WIDHT-1:0] Data_In3,
  input  logic [DATA_WIDHT-1:0] Data_In4,
  input  logic [DATA_WIDHT-1:0] Data_In5,
  input  logic [DATA_WIDHT-1:0] Data_In6,
  input  logic [DATA_WIDHT-1:0] Data_In7,
  input  logic [DATA_WIDHT-1:0] Data_In8,
  input  logic [DATA_WIDHT-1:0] Data_In9,
  input  logic                  Valid_In,
  input  logic [COEF_WIDTH-1:0] Coef_In,
  input  logic                  Coef_Valid,
  output logic                  Coef_Ready,
  output logic [DATA_WIDHT-1:0] Data_Out,
  output logic                  Valid_Out,
  output logic                  Frame_Done
);

  localparam int unsigned OUT_W      = OUT_DIM(IMG_WIDHT);
  localparam int unsigned OUT_H      = OUT_DIM(IMG_HEIGHT);
  localparam int unsigned ACC_WIDTH  = ACC_W(DATA_WIDHT, COEF_WIDTH);
  localparam int unsigned PROD_WIDTH = DATA_WIDHT + COEF_WIDTH + 1;
  localparam int unsigned COL_W      = $clog2(OUT_W);
  localparam int unsigned ROW_W      = $clog2(OUT_H);

  logic [DATA_WIDHT-1:0] pix [NUM_TAPS];
  assign pix[0] = Data_In1;
  assign pix[1] = Data_In2;
  assign pix[2] = Data_In3;
  assign pix[3] = Data_In4;
  assign pix[4] = Data_In5;
  assign pix[5] = Data_In6;
  assign pix[6] = Data_In7;
  assign pix[7] = Data_In8;
  assign pix[8] = Data_In9;

  logic signed [COEF_WIDTH-1:0] coef_q [NUM_COEF];
  logic [3:0] idx_q, idx_d, wr_idx;
  logic       ready_q, ready_d;

  // Load sequencing: a write while ready restarts the bank at K1.
  always_comb begin
    idx_d   = idx_q;
    ready_d = ready_q;
    wr_idx  = ready_q ? 4'd0 : idx_q;
    if (Coef_Valid) begin
      ready_d = 1'b0;
      if (wr_idx == 4'(BIAS_IDX)) begin
        idx_d   = 4'd0;
        ready_d = 1'b1;
      end else begin
        idx_d = wr_idx + 4'd1;
      end
    end
  end

  // Coefficient bank and load state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_COEF; i++) coef_q[i] <= '0;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      if (Coef_Valid) coef_q[wr_idx] <= Coef_In;
      idx_q   <= idx_d;
      ready_q <= ready_d;
    end
  end

  logic signed [PROD_WIDTH-1:0] prod_d [NUM_TAPS];
  logic signed [PROD_WIDTH-1:0] prod_q [NUM_TAPS];
  logic signed [ACC_WIDTH-1:0]  bias1_d, bias1_q, bias2_q;
  logic signed [ACC_WIDTH-1:0]  rsum_d [3];
  logic signed [ACC_WIDTH-1:0]  rsum_q [3];
  logic                         v1_q, v2_q;

  // S1 products and pre-scaled bias, captured with the coefficients of this edge.
  always_comb begin
    for (int i = 0; i < NUM_TAPS; i++) begin
      prod_d[i] = PROD_WIDTH'($signed({1'b0, pix[i]})) * PROD_WIDTH'(coef_q[i]);
    end
    bias1_d = ACC_WIDTH'(coef_q[BIAS_IDX]) <<< SHIFT;
  end

  // S2 row partial sums.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      rsum_d[r] = ACC_WIDTH'(prod_q[3*r]) + ACC_WIDTH'(prod_q[3*r+1])
                + ACC_WIDTH'(prod_q[3*r+2]);
    end
  end

  // S1/S2 pipeline registers; windows are dropped until the bank is complete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAPS; i++) prod_q[i] <= '0;
      for (int r = 0; r < 3; r++) rsum_q[r] <= '0;
      bias1_q <= '0;
      bias2_q <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
    end else begin
      prod_q  <= prod_d;
      bias1_q <= bias1_d;
      v1_q    <= Valid_In & ready_q;
      rsum_q  <= rsum_d;
      bias2_q <= bias1_q;
      v2_q    <= v1_q;
    end
  end

  logic signed [ACC_WIDTH-1:0]  acc_sum;
  logic        [DATA_WIDHT-1:0] sat_pix;

  assign acc_sum = rsum_q[0] + rsum_q[1] + rsum_q[2] + bias2_q;

  relu_round_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .SHIFT     (SHIFT),
    .DATA_WIDHT(DATA_WIDHT)
  ) u_relu_round_sat (
    .acc_i(acc_sum),
    .pix_o(sat_pix)
  );

  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      line_q, line_d;
  logic                  last_col, last_pix;
  logic [DATA_WIDHT-1:0] data_q;
  logic                  valid_q, frame_done_q;

  assign last_col = (col_q == COL_W'(OUT_W - 1));
  assign last_pix = last_col && (line_q == ROW_W'(OUT_H - 1));

  // Raster position of the next output pixel.
  always_comb begin
    col_d  = col_q;
    line_d = line_q;
    if (v2_q) begin
      if (last_col) begin
        col_d  = '0;
        line_d = last_pix ? '0 : line_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // S3 output registers; Data_Out holds between valid pixels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      line_q       <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      line_q       <= line_d;
      valid_q      <= v2_q;
      frame_done_q <= v2_q & last_pix;
      if (v2_q) data_q <= sat_pix;
    end
  end

  assign Coef_Ready = ready_q;
  assign Data_Out   = data_q;
  assign Valid_Out  = valid_q;
  assign Frame_Done = frame_done_q;

endmodule

// File: tb/tb_conv3x3_mac_stage.sv
// Directed bench for conv3x3_mac_stage with an arithmetic reference model.
module tb_conv3x3_mac_stage;

  localparam int FRAME = 149 * 149;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d [9];
  logic       Valid_In = 1'b0, Coef_Valid = 1'b0;
  logic [7:0] Coef_In = '0;
  logic       Coef_Ready, Valid_Out, Frame_Done;
  logic [7:0] Data_Out;

  conv3x3_mac_stage dut (
    .clk(clk), .rst(rst),
    .Data_In1(d[0]), .Data_In2(d[1]), .Data_In3(d[2]),
    .Data_In4(d[3]), .Data_In5(d[4]), .Data_In6(d[5]),
    .Data_In7(d[6]), .Data_In8(d[7]), .Data_In9(d[8]),
    .Valid_In(Valid_In), .Coef_In(Coef_In), .Coef_Valid(Coef_Valid),
    .Coef_Ready(Coef_Ready), .Data_Out(Data_Out), .Valid_Out(Valid_Out),
    .Frame_Done(Frame_Done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  // Reference state
  int m_k [10];
  bit m_ready = 0;
  int m_idx = 0, m_outcnt = 0;
  int kset [10];

  // Expected outputs in flight, tagged with the cycle they must appear in.
  int e_due [8], e_data [8];
  bit e_fd [8];
  int wr = 0, rd = 0;

  int got [$];
  int last_data = 0, dut_outs = 0, fd_cnt = 0, fd_at = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Dot product, bias, round-half-up, ReLU, shift and clamp in plain integers.
  function automatic int model_pix();
    int acc = 0;
    for (int i = 0; i < 9; i++) acc += int'(d[i]) * m_k[i];
    acc += m_k[9] * 64 + 32;
    if (acc < 0) return 0;
    acc = acc / 64;
    return (acc > 255) ? 255 : acc;
  endfunction

  function automatic int got_at(input int i);
    if (i < got.size()) return got[i];
    return -1;
  endfunction

  task automatic set_pix(input int c, input int o);
    for (int i = 0; i < 9; i++) d[i] = 8'(o);
    d[4] = 8'(c);
  endtask

  // One clock of stimulus; called just after a rising edge.
  task automatic step(input bit vin, input bit cv, input int cw);
    Valid_In   = vin;
    Coef_Valid = cv;
    Coef_In    = cw[7:0];
    if (vin && m_ready) begin
      m_outcnt++;
      e_due[wr % 8]  = cyc + 3;
      e_data[wr % 8] = model_pix();
      e_fd[wr % 8]   = (m_outcnt % FRAME == 0);
      wr++;
    end
    @(posedge clk);
    if (cv) begin
      if (m_ready) begin
        m_ready = 0;
        m_idx   = 0;
      end
      m_k[m_idx] = cw;
      if (m_idx == 9) begin
        m_idx   = 0;
        m_ready = 1;
      end else begin
        m_idx++;
      end
    end
    #1;
  endtask

  task automatic load();
    for (int i = 0; i < 10; i++) step(0, 1, kset[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic async_reset();
    Valid_In   = 0;
    Coef_Valid = 0;
    #2;
    rst = 1;
    #1;
    chk("rst_valid_out", Valid_Out, 0);
    chk("rst_data_out", Data_Out, 0);
    chk("rst_frame_done", Frame_Done, 0);
    chk("rst_coef_ready", Coef_Ready, 0);
    m_ready  = 0;
    m_idx    = 0;
    m_outcnt = 0;
    for (int i = 0; i < 10; i++) m_k[i] = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    bit ev;
    int ix;
    if (rst) begin
      rd        = wr;
      last_data = 0;
      dut_outs  = 0;
      fd_cnt    = 0;
      fd_at     = 0;
    end
    if (Valid_Out) begin
      dut_outs++;
      if (Frame_Done) begin
        fd_cnt++;
        fd_at = dut_outs;
      end
      got.push_back(int'(Data_Out));
    end
    ix = rd % 8;
    ev = (rd != wr) && (e_due[ix] == cyc);
    chk("valid_out", Valid_Out, ev);
    if (ev) begin
      chk("data_out", Data_Out, e_data[ix]);
      chk("frame_done", Frame_Done, e_fd[ix]);
      last_data = e_data[ix];
      rd++;
    end else begin
      chk("data_hold", Data_Out, last_data);
      chk("frame_done_idle", Frame_Done, 0);
    end
    chk("coef_ready", Coef_Ready, m_ready);
  end

  initial begin
    int base;
    for (int i = 0; i < 10; i++) m_k[i] = 0;
    set_pix(0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("init_valid_out", Valid_Out, 0);
    chk("init_data_out", Data_Out, 0);
    chk("init_coef_ready", Coef_Ready, 0);
    rst = 0;

    // Identity kernel, back-to-back windows
    kset = '{0, 0, 0, 0, 64, 0, 0, 0, 0, 0};
    load();
    base = got.size();
    set_pix(100, 7);
    step(1, 0, 0);
    set_pix(200, 9);
    step(1, 0, 0);
    idle(4);
    chk("ident_count", got.size() - base, 2);
    chk("ident_100", got_at(base), 100);
    chk("ident_200", got_at(base + 1), 200);

    // Saturation and ReLU
    kset = '{64, 64, 64, 64, 64, 64, 64, 64, 64, 0};
    load();
    base = got.size();
    set_pix(255, 255);
    step(1, 0, 0);
    kset = '{0, 0, 0, 0, -64, 0, 0, 0, 0, 0};
    load();
    set_pix(50, 77);
    step(1, 0, 0);
    idle(4);
    chk("sat_255", got_at(base), 255);
    chk("relu_neg", got_at(base + 1), 0);

    // Rounding and bias
    kset = '{0, 0, 0, 0, 32, 0, 0, 0, 0, 0};
    load();
    base = got.size();
    set_pix(3, 200);
    step(1, 0, 0);
    set_pix(1, 200);
    step(1, 0, 0);
    kset = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 10};
    load();
    set_pix(17, 250);
    step(1, 0, 0);
    set_pix(240, 3);
    step(1, 0, 0);
    kset = '{0, 0, 0, 0, 0, 0, 0, 0, 0, -1};
    load();
    set_pix(90, 90);
    step(1, 0, 0);
    idle(4);
    chk("round_1p5", got_at(base), 2);
    chk("round_0p5", got_at(base + 1), 1);
    chk("bias_10a", got_at(base + 2), 10);
    chk("bias_10b", got_at(base + 3), 10);
    chk("bias_neg", got_at(base + 4), 0);

    // Reload with windows in flight; windows during the load are dropped
    kset = '{0, 0, 0, 0, 64, 0, 0, 0, 0, 0};
    load();
    base = got.size();
    set_pix(11, 5);
    step(1, 0, 0);
    set_pix(22, 5);
    step(1, 0, 0);
    set_pix(33, 5);
    step(1, 0, 0);
    kset = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 20};
    set_pix(44, 5);
    step(1, 1, kset[0]);
    chk("reload_ready_drop", Coef_Ready, 0);
    set_pix(99, 99);
    for (int i = 1; i < 10; i++) step(1, 1, kset[i]);
    set_pix(123, 45);
    step(1, 0, 0);
    idle(4);
    chk("reload_count", got.size() - base, 5);
    chk("reload_old_0", got_at(base), 11);
    chk("reload_old_1", got_at(base + 1), 22);
    chk("reload_old_2", got_at(base + 2), 33);
    chk("reload_same_edge", got_at(base + 3), 44);
    chk("reload_new", got_at(base + 4), 20);

    // Two full frames back to back from a clean raster
    async_reset();
    set_pix(1, 1);
    step(1, 0, 0);
    kset = '{0, 0, 0, 0, 64, 0, 0, 0, 0, 0};
    load();
    for (int i = 0; i < 2 * FRAME; i++) begin
      set_pix((i * 7) % 256, i % 13);
      step(1, 0, 0);
    end
    idle(4);
    chk("frame_done_count2", fd_cnt, 2);
    chk("frame_done_pos2", fd_at, 2 * FRAME);

    // Mid-frame async reset, then a full frame after reload
    for (int i = 0; i < 500; i++) begin
      set_pix(i % 256, 1);
      step(1, 0, 0);
    end
    async_reset();
    load();
    for (int i = 0; i < FRAME; i++) begin
      set_pix((i * 3) % 256, i % 5);
      step(1, 0, 0);
    end
    idle(4);
    chk("frame_done_count_rst", fd_cnt, 1);
    chk("frame_done_pos_rst", fd_at, FRAME);
    chk("outputs_after_rst", dut_outs, FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
